// File: rtl/output_writeback_if.sv
// Bus bundles for the writeback stage: the accumulator result stream
// coming in, and the valid/ready write port going out to external memory.
interface acc_stream_if #(
  parameter int DATA_W = 32,
  parameter int X_W    = 7,
  parameter int Y_W    = 7,
  parameter int CH_W   = 4
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [CH_W-1:0]   ch;

  modport master (output data, valid, x, y, ch);
  modport slave  (input  data, valid, x, y, ch);
endinterface

interface mem_write_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          valid;
  logic          ready;

  modport master (output addr, wdata, valid, input  ready);
  modport slave  (input  addr, wdata, valid, output ready);
endinterface

// File: rtl/output_writeback.sv
// Requantizes accumulator results to IO_DATA_WIDTH, computes their memory
// address and streams them to external memory through a drop-on-full FIFO.
module output_writeback #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int FIFO_DEPTH         = 8,
  parameter int BASE_ADDR          = 0
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic [4:0]                    shift,
  acc_stream_if.slave                   acc,
  mem_write_if.master                   mem,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(EXT_MEM_HEIGHT);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int AC    = ACCUMULATION_WIDTH;
  localparam int IO    = IO_DATA_WIDTH;
  localparam int FRAME = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int WCW   = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic signed [AC:0] SAT_MAX = {{(AC - IO + 2){1'b0}}, {(IO - 1){1'b1}}};
  localparam logic signed [AC:0] SAT_MIN = {{(AC - IO + 2){1'b1}}, {(IO - 1){1'b0}}};

  logic signed [AC:0]   q_v, q_rnd, q_sum, q_shr;
  logic signed [IO-1:0] q_res;
  logic [AW-1:0]        addr_calc;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    q_v = {acc.data[AC-1], acc.data};
    if (relu_en && acc.data[AC-1])
      q_v = '0;
    q_rnd = '0;
    if (shift != 5'd0)
      q_rnd = (AC + 1)'(1) << (shift - 5'd1);
    q_sum = q_v + q_rnd;
    q_shr = q_sum >>> shift;
    if (q_shr > SAT_MAX)
      q_res = {1'b0, {(IO - 1){1'b1}}};
    else if (q_shr < SAT_MIN)
      q_res = {1'b1, {(IO - 1){1'b0}}};
    else
      q_res = q_shr[IO-1:0];
  end

  // Arithmetic modulo 2^AW gives the same result as computing wide and truncating.
  assign addr_calc = AW'(BASE_ADDR)
                   + (AW'(acc.y) * AW'(FEATURE_MAP_WIDTH) + AW'(acc.x)) * AW'(OUTPUT_NB_CHANNELS)
                   + AW'(acc.ch);

  logic                 s_valid;
  logic [AW-1:0]        s_addr;
  logic signed [IO-1:0] s_data;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
    end else if (start) begin
      s_valid <= 1'b0;
    end else begin
      s_valid <= acc.valid;
      if (acc.valid) begin
        s_addr <= addr_calc;
        s_data <= q_res;
      end
    end
  end

  logic [AW-1:0]        fifo_addr [FIFO_DEPTH];
  logic signed [IO-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic [WCW-1:0]       wcnt;
  logic                 fifo_full, fifo_empty, pop, push_ok, drop;

  assign fifo_full  = (count == (PW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && mem.ready;
  assign push_ok    = s_valid && (!fifo_full || pop);
  assign drop       = s_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok && !start) begin
      fifo_addr[wr_ptr] <= s_addr;
      fifo_data[wr_ptr] <= s_data;
    end
  end

  // The stream cannot be stalled, so a push into a full FIFO is dropped and flagged.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wcnt     <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wcnt     <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW + 1)'(push_ok) - (PW + 1)'(pop);
      if (drop)
        overflow <= 1'b1;
      done <= pop && (wcnt == WCW'(FRAME - 1));
      if (pop)
        wcnt <= (wcnt == WCW'(FRAME - 1)) ? '0 : wcnt + WCW'(1);
    end
  end

  logic signed [IO-1:0]     head_data;
  logic [EXT_MEM_WIDTH-1:0] head_wide;

  assign head_data  = fifo_data[rd_ptr];
  assign head_wide  = {{(EXT_MEM_WIDTH - IO){head_data[IO-1]}}, head_data};
  assign mem.valid  = !fifo_empty;
  assign mem.addr   = fifo_empty ? '0 : fifo_addr[rd_ptr];
  assign mem.wdata  = fifo_empty ? '0 : head_wide;
  assign fifo_count = count;

endmodule
